// File: rtl/sop_pkg.sv
// Shared definitions for the multi-channel start-of-processing generator.
// Period/phase widths up to SOP_MAX_W bits are supported by sanitize_period.
package sop_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sop_state_t;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int SOP_MAX_W = 16;

    // A zero period would never advance past the first count; force it to 1.
    function automatic logic [SOP_MAX_W-1:0] sanitize_period(input logic [SOP_MAX_W-1:0] p);
        if (p == {SOP_MAX_W{1'b0}}) begin
            sanitize_period = {{(SOP_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            sanitize_period = p;
        end
    endfunction

endpackage

// File: rtl/sop_phase_cmp.sv
// Per-channel phase comparator: registered SOP strobe on count match and
// sticky error flag for a phase that can never be reached.
module sop_phase_cmp #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_phase,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_sop,
    output logic             o_err
);

    logic r_sop;
    logic r_err;

    // Strobe one cycle after the count match; error stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sop <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_sop <= i_run && (i_cnt == i_phase);
            r_err <= r_err || (i_run && (i_phase > i_period));
        end
    end

    assign o_sop = r_sop;
    assign o_err = r_err;

endmodule

// File: rtl/sop_multi_gen.sv
// Start-of-processing generator: one shared period counter paces N_CH lanes,
// each firing a one-cycle SOP strobe at its own phase offset.
module sop_multi_gen
    import sop_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int N_CH       = 4,
    parameter int EPOCH_W    = 16,
    parameter int DEF_PERIOD = 255
) (
    input  logic                  clk_line,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  start,
    input  logic [CNT_W-1:0]      period_i,
    input  logic                  period_ld,
    input  logic [N_CH*CNT_W-1:0] phase_i,
    output logic [N_CH-1:0]       sop_o,
    output logic                  wrap_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic [EPOCH_W-1:0]    epoch_o,
    output logic [N_CH-1:0]       phase_err_o
);

    localparam logic [CNT_W-1:0]   DEF_P     = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};

    sop_state_t          r_state;
    sop_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_act;
    logic [CNT_W-1:0]    r_shd;
    logic [EPOCH_W-1:0]  r_epoch;
    logic                r_wrap;
    logic                w_run;
    logic                w_wrap;
    logic [CNT_W-1:0]    w_period_san;
    logic [CNT_W-1:0]    w_shd_nxt;

    assign w_run        = (r_state == ST_RUN);
    assign w_wrap       = w_run && (r_cnt == r_act);
    assign w_period_san = CNT_W'(sanitize_period(SOP_MAX_W'(period_i)));
    // A load coinciding with a wrap must reach the active register at that wrap.
    assign w_shd_nxt    = period_ld ? w_period_san : r_shd;

    // State register.
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave RUN only at a period boundary so stops are graceful.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (((mode == MODE_FREE) && en) || ((mode == MODE_ONESHOT) && start)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_wrap && ((mode == MODE_ONESHOT) || !en)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter, epoch and period registers; active period never changes mid-period.
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_act   <= DEF_P;
            r_shd   <= DEF_P;
            r_epoch <= {EPOCH_W{1'b0}};
            r_wrap  <= 1'b0;
        end else begin
            r_shd  <= w_shd_nxt;
            r_wrap <= w_wrap;
            if (w_run) begin
                if (w_wrap) begin
                    r_cnt   <= {CNT_W{1'b0}};
                    r_epoch <= r_epoch + EPOCH_ONE;
                    r_act   <= w_shd_nxt;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= {CNT_W{1'b0}};
                r_act <= w_shd_nxt;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        sop_phase_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .clk      (clk_line),
            .rst      (rst),
            .i_run    (w_run),
            .i_cnt    (r_cnt),
            .i_phase  (phase_i[k*CNT_W +: CNT_W]),
            .i_period (r_act),
            .o_sop    (sop_o[k]),
            .o_err    (phase_err_o[k])
        );
    end

    assign wrap_o  = r_wrap;
    assign busy_o  = w_run;
    assign cnt_o   = r_cnt;
    assign epoch_o = r_epoch;

endmodule

// File: tb/tb_sop_multi_gen.sv
// Self-checking bench for sop_multi_gen: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural reference model.
module tb_sop_multi_gen;

    localparam int CNT_W   = 8;
    localparam int N_CH    = 4;
    localparam int EPOCH_W = 16;

    logic                  clk_line = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  mode;
    logic                  start;
    logic [CNT_W-1:0]      period_i;
    logic                  period_ld;
    logic [N_CH*CNT_W-1:0] phase_i;
    logic [N_CH-1:0]       sop_o;
    logic                  wrap_o;
    logic                  busy_o;
    logic [CNT_W-1:0]      cnt_o;
    logic [EPOCH_W-1:0]    epoch_o;
    logic [N_CH-1:0]       phase_err_o;

    always #5 clk_line = ~clk_line;

    sop_multi_gen #(
        .CNT_W      (CNT_W),
        .N_CH       (N_CH),
        .EPOCH_W    (EPOCH_W),
        .DEF_PERIOD (255)
    ) dut (
        .clk_line    (clk_line),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .start       (start),
        .period_i    (period_i),
        .period_ld   (period_ld),
        .phase_i     (phase_i),
        .sop_o       (sop_o),
        .wrap_o      (wrap_o),
        .busy_o      (busy_o),
        .cnt_o       (cnt_o),
        .epoch_o     (epoch_o),
        .phase_err_o (phase_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state (plain integers).
    bit        m_run;
    int        m_cnt;
    int        m_act;
    int        m_shd;
    int        m_epoch;
    bit [3:0]  m_sop;
    bit        m_wrap;
    bit [3:0]  m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        int nshd;
        int ph;
        bit [3:0] nsop;
        bit nwrap;
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_act = 255; m_shd = 255; m_epoch = 0;
            m_sop = 4'b0; m_wrap = 1'b0; m_err = 4'b0;
        end else begin
            nshd  = period_ld ? ((period_i == 8'd0) ? 1 : int'(period_i)) : m_shd;
            nsop  = 4'b0;
            nwrap = 1'b0;
            if (m_run) begin
                for (int k = 0; k < N_CH; k++) begin
                    ph = int'(phase_i[k*CNT_W +: CNT_W]);
                    nsop[k] = (m_cnt == ph);
                    if (ph > m_act) m_err[k] = 1'b1;
                end
                nwrap = (m_cnt == m_act);
                if (nwrap) begin
                    m_cnt   = 0;
                    m_epoch = (m_epoch + 1) % 65536;
                    m_act   = nshd;
                    if (mode || !en) m_run = 1'b0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_act = nshd;
                m_cnt = 0;
                if ((!mode && en) || (mode && start)) m_run = 1'b1;
            end
            m_shd  = nshd;
            m_sop  = nsop;
            m_wrap = nwrap;
        end
    endtask

    task automatic tick();
        @(posedge clk_line);
        model_step();
        cyc++;
        #1;
        check_val("sop",   32'(sop_o),       32'(m_sop));
        check_val("wrap",  32'(wrap_o),      32'(m_wrap));
        check_val("busy",  32'(busy_o),      32'(m_run));
        check_val("cnt",   32'(cnt_o),       32'(m_cnt));
        check_val("epoch", 32'(epoch_o),     32'(m_epoch));
        check_val("perr",  32'(phase_err_o), 32'(m_err));
    endtask

    task automatic set_phases(input int p0, input int p1, input int p2, input int p3);
        phase_i = {8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic load_period(input int p);
        period_i  = 8'(p);
        period_ld = 1'b1;
        tick();
        period_ld = 1'b0;
    endtask

    int first_sop;
    int sop_t[$];
    int wrap_t[$];
    int busy_n;
    int sop_n[4];
    int ticks;

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0;
        period_i = 8'd0; period_ld = 1'b0; phase_i = 32'd0;

        // Reset defaults: period 256, phase 0.
        do_reset(3);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_cnt",  32'(cnt_o),  32'd0);
        first_sop = -1;
        for (int i = 1; i <= 520; i++) begin
            tick();
            if (sop_o[0]) sop_t.push_back(i);
            if (i == 258) check_val("epoch_after_wrap", 32'(epoch_o), 32'd1);
        end
        if (sop_t.size() > 0) first_sop = sop_t[0];
        check_val("first_sop_lat", 32'(first_sop), 32'd2);
        check_val("sop_count", 32'(sop_t.size()), 32'd3);
        if (sop_t.size() >= 2) check_val("sop_interval", 32'(sop_t[1] - sop_t[0]), 32'd256);

        // Phase spread on period 9; wrap aligns with phase 9.
        en = 1'b0;
        do_reset(1);
        set_phases(0, 3, 6, 9);
        load_period(9);
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wrap_o) check_val("wrap_align_sop3", 32'(sop_o[3]), 32'd1);
            if (sop_o[1]) check_val("sop1_cnt", 32'(cnt_o), 32'd4);
        end

        // One-shot: period 4, one start, a second start during RUN ignored.
        en = 1'b0;
        do_reset(1);
        mode = 1'b1;
        set_phases(0, 1, 2, 3);
        load_period(4);
        busy_n = 0;
        sop_n = '{0, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            start = (i == 0) || (i == 2);
            tick();
            if (busy_o) busy_n++;
            for (int k = 0; k < N_CH; k++) if (sop_o[k]) sop_n[k]++;
        end
        start = 1'b0;
        check_val("oneshot_busy_len", 32'(busy_n), 32'd5);
        for (int k = 0; k < N_CH; k++) check_val("oneshot_sop_n", 32'(sop_n[k]), 32'd1);
        check_val("oneshot_idle", 32'(busy_o), 32'd0);

        // Period change mid-period, then a zero period.
        mode = 1'b0;
        do_reset(1);
        en = 1'b0;
        load_period(9);
        en = 1'b1;
        for (int i = 0; i < 40 && cnt_o != 8'd5; i++) tick();
        check_val("wait_cnt5", 32'(cnt_o), 32'd5);
        period_i = 8'd20; period_ld = 1'b1;
        tick();
        period_ld = 1'b0;
        wrap_t.delete();
        for (int i = 0; i < 60 && wrap_t.size() < 3; i++) begin
            tick();
            if (wrap_o) wrap_t.push_back(cyc);
        end
        check_val("wrap_seen", 32'(wrap_t.size()), 32'd3);
        if (wrap_t.size() >= 2) check_val("new_period_len", 32'(wrap_t[1] - wrap_t[0]), 32'd21);
        period_i = 8'd0; period_ld = 1'b1;
        tick();
        period_ld = 1'b0;
        wrap_t.delete();
        for (int i = 0; i < 60 && wrap_t.size() < 3; i++) begin
            tick();
            if (wrap_o) wrap_t.push_back(cyc);
        end
        if (wrap_t.size() >= 3) check_val("zero_period_len", 32'(wrap_t[2] - wrap_t[1]), 32'd2);
        else check_val("zero_period_wraps", 32'(wrap_t.size()), 32'd3);

        // Unreachable phase and graceful stop.
        en = 1'b0;
        do_reset(1);
        set_phases(0, 3, 6, 30);
        load_period(9);
        en = 1'b1;
        sop_n[3] = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (sop_o[3]) sop_n[3]++;
        end
        check_val("perr_silent", 32'(sop_n[3]), 32'd0);
        check_val("perr_set", 32'(phase_err_o), 32'h8);
        for (int i = 0; i < 20 && cnt_o != 8'd2; i++) tick();
        check_val("wait_cnt2", 32'(cnt_o), 32'd2);
        en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 30 && busy_o; i++) begin
            tick();
            ticks++;
        end
        check_val("stop_ticks", 32'(ticks), 32'd8);
        check_val("perr_sticky", 32'(phase_err_o), 32'h8);

        // Reset in the middle of a period.
        en = 1'b1;
        set_phases(0, 3, 4, 5);
        for (int i = 0; i < 20 && cnt_o != 8'd4; i++) tick();
        check_val("wait_cnt4", 32'(cnt_o), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        check_val("midrst_sop",   32'(sop_o),       32'd0);
        check_val("midrst_busy",  32'(busy_o),      32'd0);
        check_val("midrst_perr",  32'(phase_err_o), 32'd0);
        tick();
        check_val("midrst_nostrobe", 32'({sop_o, wrap_o}), 32'd0);

        // Randomized traffic against the model.
        load_period(5);
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 9) != 0);
            mode      = ($urandom_range(0, 3) == 0);
            start     = ($urandom_range(0, 7) == 0);
            period_ld = ($urandom_range(0, 11) == 0);
            period_i  = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 31) == 0) begin
                set_phases($urandom_range(0, 14), $urandom_range(0, 14),
                           $urandom_range(0, 14), $urandom_range(0, 14));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
